// File: rtl/spi_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_master: SPI mode-0 (CPOL=0, CPHA=0) full-duplex master, MSB first  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_HOLD = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t                  state_q,   state_d;
  logic                    accept_q,  accept_d;
  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_sr_q,   tx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q,   rx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    sclk_q,    sclk_d;
  logic                    cs_q,      cs_d;
  logic                    mosi_q,    mosi_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    phase_end;

  assign phase_end = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    accept_d  = 1'b0;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != S_IDLE) begin
      div_cnt_d = phase_end ? '0 : div_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // Accepted start is registered one cycle; the frame opens on the next edge.
        if (accept_q) begin
          tx_sr_d   = tx_data;
          mosi_d    = tx_data[DATA_WIDTH-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = S_LOW;
        end else if (start) begin
          accept_d = 1'b1;
        end
      end

      S_LOW: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end

      S_HIGH: begin
        if (phase_end) begin
          rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
          sclk_d  = 1'b0;
          if (bit_cnt_q != BIT_LAST) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_sr_d   = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d    = tx_sr_q[DATA_WIDTH-2];
            state_d   = S_LOW;
          end else begin
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (phase_end) begin
          cs_d      = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      accept_q  <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      accept_q  <= accept_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_spi_master: directed self-checking bench for spi_master             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b, start_c;
  logic [7:0] tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] rx_a, rx_b, rx_c;
  logic       sclk_a, sclk_b, sclk_c;
  logic       cs_a, cs_b, cs_c;
  logic       mosi_a, mosi_b, mosi_c;
  logic       miso_a, miso_b, miso_c;

  // Slave model on DUT a: presents slv_byte MSB first, advancing after each sclk fall.
  logic       loop_a;
  logic [7:0] slv_byte;
  logic [3:0] slv_idx = 4'd0;
  logic       sclk_seen = 1'b0;
  logic       slv_bit;

  always @(negedge clk) begin
    if (cs_a) slv_idx <= 4'd0;
    else if (sclk_seen && !sclk_a) slv_idx <= slv_idx + 4'd1;
    sclk_seen <= sclk_a;
  end

  assign slv_bit = slv_idx[3] ? 1'b0 : slv_byte[3'd7 - slv_idx[2:0]];
  assign miso_a  = loop_a ? mosi_a : slv_bit;
  assign miso_b  = mosi_b;
  assign miso_c  = mosi_c;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .busy(busy_a), .done(done_a),
    .rx_data(rx_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .busy(busy_b), .done(done_b),
    .rx_data(rx_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .tx_data(tx_c), .busy(busy_c), .done(done_c),
    .rx_data(rx_c), .sclk(sclk_c), .cs(cs_c), .mosi(mosi_c), .miso(miso_c));

  int vectors    = 0;
  int miscompares = 0;

  // Per-window observations
  int         n_cs_low, n_cs_fall, n_rise, hi_min, hi_max, lo_min, lo_max, busy_fall, cs_gap;
  logic [7:0] mosi_seq;
  bit         mosi_chg_hi, done_wo_busy;
  logic       t0_cs, t0_busy;
  logic [4:0] snap;
  logic [7:0] snap_rx;
  int         done_t[$];
  logic [7:0] done_rx[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qt(input int i);
    return (done_t.size() > i) ? 32'(done_t[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qrx(input int i);
    return (done_rx.size() > i) ? 32'(done_rx[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic drv(input int k, input logic st, input logic [7:0] tx);
    case (k)
      0:       begin start_a = st; tx_a = tx; end
      1:       begin start_b = st; tx_b = tx; end
      default: begin start_c = st; tx_c = tx; end
    endcase
  endtask

  task automatic samp(input int k, output logic s, output logic c, output logic m,
                      output logic d, output logic b, output logic [7:0] rx);
    case (k)
      0:       begin s = sclk_a; c = cs_a; m = mosi_a; d = done_a; b = busy_a; rx = rx_a; end
      1:       begin s = sclk_b; c = cs_b; m = mosi_b; d = done_b; b = busy_b; rx = rx_b; end
      default: begin s = sclk_c; c = cs_c; m = mosi_c; d = done_c; b = busy_c; rx = rx_c; end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Present start for one edge (the accepting edge); returns at the following negedge.
  task automatic kick(input int k, input logic [7:0] tx);
    drv(k, 1'b1, tx);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sample t is taken t cycles after the accepting edge; drives after sample t hit edge t+1.
  task automatic watch(input int k, input int ncyc, input logic [7:0] tx0, input int hold_until,
                       input int pulse_at, input int alt_at, input logic [7:0] alt_tx,
                       input int rst_at);
    logic s, c, m, d, b, ps, pc, pm, pb;
    logic [7:0] rx, cur_tx;
    int hi_run, lo_run, gap_run;
    bit seen_low;
    n_cs_low = 0; n_cs_fall = 0; n_rise = 0; busy_fall = -1; cs_gap = -1;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    mosi_seq = 8'h00; mosi_chg_hi = 0; done_wo_busy = 0; snap = 5'h1F; snap_rx = 8'hEE;
    done_t.delete(); done_rx.delete();
    ps = 1'b0; pc = 1'b1; pm = 1'b0; pb = 1'b0;
    hi_run = 0; lo_run = 0; gap_run = 0; seen_low = 0; cur_tx = tx0;
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      samp(k, s, c, m, d, b, rx);
      if (t == 0) begin t0_cs = c; t0_busy = b; end
      if (t == rst_at + 1) begin snap = {c, s, m, b, d}; snap_rx = rx; end
      if (!c) begin
        if (pc) begin
          n_cs_fall++;
          if (seen_low) cs_gap = gap_run;
        end
        n_cs_low++; seen_low = 1; gap_run = 0;
      end else if (seen_low) begin
        gap_run++;
      end
      if (s && !ps) begin
        if (lo_run > 0) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        lo_run = 0; hi_run = 1; n_rise++; mosi_seq = {mosi_seq[6:0], m};
      end else if (s) begin
        hi_run++;
        if (m !== pm) mosi_chg_hi = 1;
      end else if (ps) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0; lo_run = c ? 0 : 1;
      end else begin
        lo_run = c ? 0 : lo_run + 1;
      end
      if (d === 1'b1) begin
        done_t.push_back(t); done_rx.push_back(rx);
        if (b !== 1'b1) done_wo_busy = 1;
      end
      if (pb && !b && busy_fall < 0) busy_fall = t;
      ps = s; pc = c; pm = m; pb = b;
      if (t == alt_at) cur_tx = alt_tx;
      drv(k, (t < hold_until) || (t == pulse_at), cur_tx);
      rst = (t == rst_at);
    end
  endtask

  // One complete frame: cs low (2*8+1)*cd cycles, done one cycle later, busy cd cycles after done.
  task automatic frame_checks(input string p, input int cd, input logic [7:0] exp_mosi,
                              input logic [7:0] exp_rx);
    check({p, " t0_cs"},      32'(t0_cs), 32'd1);
    check({p, " t0_busy"},    32'(t0_busy), 32'd0);
    check({p, " cs_low"},     n_cs_low, 17 * cd);
    check({p, " cs_falls"},   n_cs_fall, 1);
    check({p, " done_count"}, done_t.size(), 1);
    check({p, " done_time"},  qt(0), 17 * cd + 1);
    check({p, " rx_data"},    qrx(0), 32'(exp_rx));
    check({p, " mosi_seq"},   32'(mosi_seq), 32'(exp_mosi));
    check({p, " sclk_rises"}, n_rise, 8);
    check({p, " hi_min"},     hi_min, cd);
    check({p, " hi_max"},     hi_max, cd);
    check({p, " lo_min"},     lo_min, cd);
    check({p, " lo_max"},     lo_max, cd);
    check({p, " mosi_hi"},    32'(mosi_chg_hi), 32'd0);
    check({p, " done_busy"},  32'(done_wo_busy), 32'd0);
    check({p, " busy_fall"},  busy_fall, 18 * cd + 1);
  endtask

  initial begin
    rst = 1'b1; loop_a = 1'b1; slv_byte = 8'hA5;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tx_a = 8'h00; tx_b = 8'h00; tx_c = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cs",   32'(cs_a), 32'd1);
    check("rst sclk", 32'(sclk_a), 32'd0);
    check("rst mosi", 32'(mosi_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst rx",   32'(rx_a), 32'd0);
    check("rst cs_b", 32'(cs_b), 32'd1);
    check("rst cs_c", 32'(cs_c), 32'd1);
    rst = 1'b0;
    idle(3);

    kick(0, 8'h3C);
    watch(0, 45, 8'h3C, 0, -1, -1, 8'h00, -10);
    frame_checks("loop3c", 2, 8'h3C, 8'h3C);
    check("loop3c rx_out", 32'(rx_a), 32'h3C);
    idle(2);

    loop_a = 1'b0;
    kick(0, 8'h3C);
    watch(0, 45, 8'h3C, 0, -1, -1, 8'h00, -10);
    frame_checks("slaveA5", 2, 8'h3C, 8'hA5);
    loop_a = 1'b1;
    idle(2);

    kick(1, 8'hFF);
    watch(1, 30, 8'hFF, 0, -1, -1, 8'h00, -10);
    frame_checks("div1", 1, 8'hFF, 8'hFF);

    kick(2, 8'h00);
    watch(2, 90, 8'h00, 0, -1, -1, 8'h00, -10);
    frame_checks("div4", 4, 8'h00, 8'h00);
    idle(2);

    // start + new tx_data during bit 3 LOW phase must be dropped, not queued
    kick(0, 8'h3C);
    watch(0, 60, 8'h3C, 0, 13, 13, 8'h55, -10);
    frame_checks("busy_start", 2, 8'h3C, 8'h3C);
    idle(2);

    // sample 19 is the first cycle of bit 4's HIGH phase; rst takes effect at edge 20
    kick(0, 8'h3C);
    watch(0, 30, 8'h3C, 0, -1, -1, 8'h00, 19);
    check("abort state", 32'(snap), 32'h10);
    check("abort rx",    32'(snap_rx), 32'h00);
    check("abort done",  done_t.size(), 0);
    check("abort rises", n_rise, 5);
    check("abort busy",  busy_fall, 20);
    idle(3);

    kick(0, 8'h81);
    watch(0, 45, 8'h81, 0, -1, -1, 8'h00, -10);
    frame_checks("after_rst", 2, 8'h81, 8'h81);
    idle(2);

    // start held high: second accept on edge 38 (first IDLE cycle), cs high over samples 35..38
    kick(0, 8'h12);
    watch(0, 90, 8'h12, 40, -1, 1, 8'h34, -10);
    check("b2b done_count", done_t.size(), 2);
    check("b2b done0_t",    qt(0), 35);
    check("b2b done1_t",    qt(1), 73);
    check("b2b rx0",        qrx(0), 32'h12);
    check("b2b rx1",        qrx(1), 32'h34);
    check("b2b cs_falls",   n_cs_fall, 2);
    check("b2b cs_gap",     cs_gap, 4);
    check("b2b cs_low",     n_cs_low, 68);
    check("b2b rises",      n_rise, 16);
    check("b2b mosi_last",  32'(mosi_seq), 32'h34);
    check("b2b busy_fall",  busy_fall, 37);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
